// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter: FSM states, JK command
// encodings and the per-bit JK next-state function.
package jk_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   function automatic logic jk_next(input logic j, input logic k, input logic q);
      logic r;
      case ({j, k})
         JK_HOLD: r = q;
         JK_RST:  r = 1'b0;
         JK_SET:  r = 1'b1;
         JK_TGL:  r = ~q;
         default: r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr.sv
// Combinational round-robin picker: first set request scanning from ptr
// upward, modulo NREQ. Produces a one-hot winner and its binary index.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IW'((32'(ptr) + k) % NREQ);
         if (!found && req[cand]) begin
            found        = 1'b1;
            idx          = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Shares one WIDTH-bit JK flip-flop bank between NREQ requesters; each
// command takes IDLE -> APPLY -> ACK with registered gnt/done/busy.
module jk_bank_arbiter
   import jk_bank_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] j_in,
   input  logic [NREQ*WIDTH-1:0] k_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      q,
   output logic                  busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win;
   logic [WIDTH-1:0] j_lat;
   logic [WIDTH-1:0] k_lat;
   logic [NREQ-1:0]  arb_oh;
   logic [IW-1:0]    arb_idx;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req    (req),
      .ptr    (ptr),
      .onehot (arb_oh),
      .idx    (arb_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         q     <= '0;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         win   <= '0;
         j_lat <= '0;
         k_lat <= '0;
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  // masks are captured here so later changes cannot alter the command
                  win   <= arb_idx;
                  j_lat <= j_in[32'(arb_idx)*WIDTH +: WIDTH];
                  k_lat <= k_in[32'(arb_idx)*WIDTH +: WIDTH];
                  gnt   <= arb_oh;
                  busy  <= 1'b1;
                  state <= APPLY;
               end
            end
            APPLY: begin
               for (int unsigned b = 0; b < WIDTH; b++)
                  q[b] <= jk_next(j_lat[b], k_lat[b], q[b]);
               done  <= gnt;
               state <= ACK;
            end
            ACK: begin
               ptr   <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (NREQ=4, WIDTH=8).
module tb_jk_bank_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] j_in;
   logic [31:0] k_in;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [7:0]  q;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   jk_bank_arbiter #(
      .NREQ  (4),
      .WIDTH (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .j_in (j_in),
      .k_in (k_in),
      .gnt  (gnt),
      .done (done),
      .q    (q),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_mask(input int r, input logic [7:0] j, input logic [7:0] k);
      j_in[r*8 +: 8] = j;
      k_in[r*8 +: 8] = k;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) cyc();
      rst = 1'b1;
   endtask

   // single requester command; checks gnt in APPLY, done and q in ACK, idle after
   task automatic issue(input int r, input logic [7:0] j, input logic [7:0] k,
                        input logic [7:0] exp_q);
      logic [3:0] oh;
      oh = 4'b0001 << r;
      set_mask(r, j, k);
      req = oh;
      cyc();
      chk("issue_gnt", 32'(gnt), 32'(oh));
      chk("issue_busy", 32'(busy), 32'd1);
      cyc();
      chk("issue_done", 32'(done), 32'(oh));
      chk("issue_q", 32'(q), 32'(exp_q));
      req = 4'b0000;
      cyc();
      chk("issue_idle", 32'({busy, gnt, done}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] exp_oh;
      rst  = 1'b0;
      req  = 4'b1111;
      j_in = '0;
      k_in = '0;

      // 1 reset with all requests asserted
      repeat (2) cyc();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      req = 4'b0000;
      rst = 1'b1;
      cyc();

      // 2 set / reset / toggle / hold on requester 0
      issue(0, 8'hFF, 8'h00, 8'hFF);
      issue(0, 8'h00, 8'h0F, 8'hF0);
      issue(0, 8'h3C, 8'h3C, 8'hCC);
      issue(0, 8'h00, 8'h00, 8'hCC);

      // 3 round robin from ptr=0 with all requests held
      do_reset();
      chk("rr_q_reset", 32'(q), 32'h00);
      for (int i = 0; i < 4; i++) set_mask(i, 8'(1 << i), 8'h00);
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         exp_oh = 4'b0001 << (t % 4);
         cyc();
         chk("rr_gnt", 32'(gnt), 32'(exp_oh));
         chk("rr_done_apply", 32'(done), 32'h0);
         cyc();
         chk("rr_done", 32'(done), 32'(exp_oh));
         chk("rr_gnt_ack", 32'(gnt), 32'h0);
         if (t == 4) req = 4'b0000;
         cyc();
         chk("rr_idle", 32'({gnt, done}), 32'h0);
      end
      chk("rr_q", 32'(q), 32'h0F);

      // 4 contention after wrap: serve 3 (ptr -> 0), then 1 beats 3
      issue(3, 8'h00, 8'h00, 8'h0F);
      set_mask(1, 8'h10, 8'h00);
      set_mask(3, 8'h80, 8'h00);
      req = 4'b1010;
      cyc();
      chk("wrap_gnt1", 32'(gnt), 32'h2);
      cyc();
      chk("wrap_done1", 32'(done), 32'h2);
      chk("wrap_q1", 32'(q), 32'h1F);
      req = 4'b1000;
      cyc();
      cyc();
      chk("wrap_gnt3", 32'(gnt), 32'h8);
      cyc();
      chk("wrap_done3", 32'(done), 32'h8);
      chk("wrap_q3", 32'(q), 32'h9F);
      req = 4'b0000;
      cyc();

      // 5 mask change during APPLY is ignored
      do_reset();
      set_mask(2, 8'h01, 8'h00);
      req = 4'b0100;
      cyc();
      chk("mask_gnt", 32'(gnt), 32'h4);
      set_mask(2, 8'hFF, 8'h00);
      cyc();
      chk("mask_done", 32'(done), 32'h4);
      chk("mask_q", 32'(q), 32'h01);
      req = 4'b0000;
      cyc();

      // 6 reset during APPLY; ptr was 3 so requester 3 wins first, then 1 after reset
      set_mask(1, 8'hF0, 8'h00);
      set_mask(3, 8'h0F, 8'h00);
      req = 4'b1010;
      cyc();
      chk("mid_gnt_pre", 32'(gnt), 32'h8);
      rst = 1'b0;
      cyc();
      chk("mid_q", 32'(q), 32'h00);
      chk("mid_flags", 32'({busy, gnt, done}), 32'h0);
      rst = 1'b1;
      cyc();
      chk("mid_gnt_post", 32'(gnt), 32'h2);
      chk("mid_no_done", 32'(done), 32'h0);
      cyc();
      chk("mid_done", 32'(done), 32'h2);
      chk("mid_q_after", 32'(q), 32'hF0);
      req = 4'b0000;
      cyc();
      chk("mid_idle", 32'({busy, gnt, done}), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
